hawk_axi_wr_chnl: RTL and testbench
===================================

Name: hawk_axi_wr_chnl

Overview:
- Downstream AXI4 write-channel stage for the compress/decompress write manager. It takes single-cycle AW and W requests and registers them into AXI AW/W valid/payload, holding each valid until its ready handshake.
- It feeds the registered AW/W state back to the manager as that manager's view of the live request.
- It tracks outstanding B responses against a credit limit, flags response and protocol errors, and provides a drain/flush handshake so the page-update sequence can confirm all writes landed before signalling done.

Parameters:
- ADDR_W, 64, AXI address width
- DATA_W, 512, AXI data width (one 64 B cache line)
- ID_W, 4, AXI ID width
- AWID_VAL, 0, constant AWID driven on every write
- MAX_OUTST, 8, maximum writes with AW accepted but B not yet received (>=1)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- aw_req_i  in  1  pulse: load AW register
- aw_addr_i  in  ADDR_W  write address, 64 B aligned
- w_req_i  in  1  pulse: load W register
- w_data_i  in  DATA_W  write data
- w_strb_i  in  DATA_W/8  byte strobes
- flush_i  in  1  pulse: drain all pending writes
- awvalid_q_o  out  1  registered AW valid (manager feedback)
- wvalid_q_o  out  1  registered W valid (manager feedback)
- addr_q_o  out  ADDR_W  last loaded AW address (manager feedback for +64 stepping)
- aw_busy_o  out  1  awvalid_q_o OR credit exhausted
- m_awid/awaddr/awlen/awsize/awburst/awvalid  out  ID_W/ADDR_W/8/3/2/1  AXI AW
- m_awready  in  1
- m_wdata/wstrb/wlast/wvalid  out  DATA_W/DATA_W/8/1/1  AXI W
- m_wready  in  1
- m_bid/bresp/bvalid  in  ID_W/2/1  AXI B
- m_bready  out  1
- outst_cnt_o  out  $clog2(MAX_OUTST+1)  outstanding count
- idle_o  out  1  no AW/W pending and outst_cnt_o==0
- flush_done_o  out  1  one-cycle pulse when drain completes
- err_o  out  2  sticky: [0] bresp!=OKAY, [1] protocol error (dropped request or unexpected B)

Behaviour:
- Reset: all valids 0, addr_q_o/data/strb 0, count 0, err_o 0, flush_done_o 0, FSM RUN.
- Constants: awlen=0, awsize=3'd6, awburst=INCR, wlast=1, awid=AWID_VAL. Single-beat writes only.
- AW load: aw_req_i && !awvalid_q && cnt<MAX_OUTST → next cycle awvalid_q=1, addr_q=aw_addr_i (1-cycle latency). Clears the cycle after awvalid&&awready.
- aw_req_i while aw_busy_o → request dropped, AW register unchanged, err_o[1] set.
- W load: w_req_i && !wvalid_q → latch data/strb, wvalid_q=1. Clears on wvalid&&wready.
- w_req_i while wvalid_q → dropped, err_o[1] set.
- W may precede, follow or coincide with AW; no ordering enforced.
- Counter: +1 on AW handshake, -1 on B handshake; both in the same cycle → unchanged. Saturates by construction (AW is blocked at MAX).
- m_bready = (cnt!=0).
- B arriving with cnt==0 is not accepted (bready low). Any bvalid seen with cnt==0 sets err_o[1].
- bresp!=2'b00 on B handshake sets err_o[0]. Errors are cleared only by reset.
- FSM:
  - RUN: flush_i → DRAIN.
  - DRAIN: new requests are still accepted. When idle_o → DONE.
  - DONE: flush_done_o=1 for one cycle → RUN.
- flush_i while already idle: DRAIN→DONE gives flush_done_o 2 cycles after flush_i.
- flush_i in DRAIN or DONE is ignored.
- Reset mid-transaction abandons all pending AW/W/count immediately, with no AXI cleanup. The interconnect is reset on the same rst_ni.

Decomposition:
- hacd_pkg: AXI constants (AXI_SIZE_64B=3'd6, AXI_BURST_INCR=2'b01, AXI_RESP_OKAY=2'b00) and a wr-channel FSM state enum.
- Natural sub-module: hawk_axi_hold_reg, a parameterised valid/payload holding register (load, hold until ready, busy). Instantiated twice, for AW and W.

Test Plan:
- Single write: aw_req addr=0x1000 and w_req data={32{16'h1234}}, strb all-ones; awready/wready 1 → awvalid 1 cycle, cnt 0→1; B OKAY → cnt 0, idle_o=1.
- Backpressure: awready=0 for 5 cycles → awvalid and addr 0x1000 held stable 5 cycles, aw_busy_o=1. Second aw_req in that window dropped, err_o=2'b10.
- Credit limit: 8 AWs with no B → cnt=8, aw_busy_o=1. 9th aw_req dropped. Single B → cnt=7, next aw_req accepted.
- Simultaneous AW and B handshake at cnt=3 → cnt stays 3.
- Flush: 64 writes at 0x4000+64*i streaming, flush_i after the 10th → flush_done_o pulses exactly one cycle after the final B, cnt=0.
- Error: B with bresp=2'b10 → err_o[0]=1, stays set through later OKAY responses; cleared only by rst_ni.

Source files
------------

// File: rtl/hacd_pkg.sv
// Shared constants and types for the compress/decompress write path.
// Holds AXI encodings and the write-channel drain FSM state type.
package hacd_pkg;

    localparam logic [2:0] AXI_SIZE_64B   = 3'd6;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef enum logic [1:0] {
        WR_RUN   = 2'd0,
        WR_DRAIN = 2'd1,
        WR_DONE  = 2'd2
    } wr_state_e;

endpackage

// File: rtl/hawk_axi_hold_reg.sv
// Valid/payload holding register: loads on an unblocked request and holds
// until ready. Ports: req_i/block_i/data_i in, ready_i in, valid_o/data_o/drop_o out.
module hawk_axi_hold_reg #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         req_i,
    input  logic         block_i,
    input  logic [W-1:0] data_i,
    input  logic         ready_i,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    output logic         drop_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;
    logic         busy;
    logic         load;

    // A request arriving in the handshake cycle is still dropped: the
    // register only reloads once it has been observed empty.
    assign busy   = valid_q | block_i;
    assign load   = req_i & ~busy;
    assign drop_o = req_i & busy;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/hawk_axi_wr_chnl.sv
// AXI4 single-beat write channel: registers AW/W, tracks B credits, flags errors
// and runs a flush/drain handshake. Ports: manager req/feedback, AXI AW/W/B, status.
module hawk_axi_wr_chnl
    import hacd_pkg::*;
#(
    parameter int unsigned ADDR_W    = 64,
    parameter int unsigned DATA_W    = 512,
    parameter int unsigned ID_W      = 4,
    parameter int unsigned AWID_VAL  = 0,
    parameter int unsigned MAX_OUTST = 8,
    localparam int unsigned CNT_W    = $clog2(MAX_OUTST + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                aw_req_i,
    input  logic [ADDR_W-1:0]   aw_addr_i,
    input  logic                w_req_i,
    input  logic [DATA_W-1:0]   w_data_i,
    input  logic [DATA_W/8-1:0] w_strb_i,
    input  logic                flush_i,
    output logic                awvalid_q_o,
    output logic                wvalid_q_o,
    output logic [ADDR_W-1:0]   addr_q_o,
    output logic                aw_busy_o,
    output logic [ID_W-1:0]     m_awid,
    output logic [ADDR_W-1:0]   m_awaddr,
    output logic [7:0]          m_awlen,
    output logic [2:0]          m_awsize,
    output logic [1:0]          m_awburst,
    output logic                m_awvalid,
    input  logic                m_awready,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic                m_wlast,
    output logic                m_wvalid,
    input  logic                m_wready,
    input  logic [ID_W-1:0]     m_bid,
    input  logic [1:0]          m_bresp,
    input  logic                m_bvalid,
    output logic                m_bready,
    output logic [CNT_W-1:0]    outst_cnt_o,
    output logic                idle_o,
    output logic                flush_done_o,
    output logic [1:0]          err_o
);

    localparam int unsigned WP_W = DATA_W + DATA_W / 8;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       err_q, err_d;
    wr_state_e        state_q, state_d;

    logic             full;
    logic             aw_drop, w_drop;
    logic             aw_hs, b_hs;
    logic             cnt_zero;
    logic [WP_W-1:0]  w_pl_in, w_pl_q;
    logic             unused_bid;

    assign unused_bid = ^m_bid;

    assign full     = (cnt_q == CNT_W'(MAX_OUTST));
    assign cnt_zero = (cnt_q == '0);

    hawk_axi_hold_reg #(.W(ADDR_W)) u_aw (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .req_i  (aw_req_i),
        .block_i(full),
        .data_i (aw_addr_i),
        .ready_i(m_awready),
        .valid_o(awvalid_q_o),
        .data_o (addr_q_o),
        .drop_o (aw_drop)
    );

    assign w_pl_in = {w_strb_i, w_data_i};

    hawk_axi_hold_reg #(.W(WP_W)) u_w (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .req_i  (w_req_i),
        .block_i(1'b0),
        .data_i (w_pl_in),
        .ready_i(m_wready),
        .valid_o(wvalid_q_o),
        .data_o (w_pl_q),
        .drop_o (w_drop)
    );

    assign aw_busy_o = awvalid_q_o | full;

    assign m_awid    = ID_W'(AWID_VAL);
    assign m_awaddr  = addr_q_o;
    assign m_awlen   = 8'd0;
    assign m_awsize  = AXI_SIZE_64B;
    assign m_awburst = AXI_BURST_INCR;
    assign m_awvalid = awvalid_q_o;

    assign m_wdata  = w_pl_q[DATA_W-1:0];
    assign m_wstrb  = w_pl_q[WP_W-1:DATA_W];
    assign m_wlast  = 1'b1;
    assign m_wvalid = wvalid_q_o;

    // B is only accepted against a credit; a stray B is left hanging.
    assign m_bready = ~cnt_zero;

    assign aw_hs = awvalid_q_o & m_awready;
    assign b_hs  = m_bvalid & m_bready;

    always_comb begin
        cnt_d = cnt_q;
        if (aw_hs && !b_hs) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (b_hs && !aw_hs) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_comb begin
        err_d    = err_q;
        err_d[0] = err_q[0] | (b_hs & (m_bresp != AXI_RESP_OKAY));
        err_d[1] = err_q[1] | aw_drop | w_drop | (m_bvalid & cnt_zero);
    end

    assign idle_o = ~awvalid_q_o & ~wvalid_q_o & cnt_zero;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            WR_RUN:   if (flush_i) state_d = WR_DRAIN;
            WR_DRAIN: if (idle_o)  state_d = WR_DONE;
            WR_DONE:  state_d = WR_RUN;
            default:  state_d = WR_RUN;
        endcase
    end

    assign flush_done_o = (state_q == WR_DONE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            err_q   <= '0;
            state_q <= WR_RUN;
        end else begin
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            state_q <= state_d;
        end
    end

    assign outst_cnt_o = cnt_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_hawk_axi_wr_chnl.sv
// Directed self-checking bench for hawk_axi_wr_chnl.
// Covers reset, single write, backpressure, credits, flush and errors.
module tb_hawk_axi_wr_chnl;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         aw_req_i;
    logic [63:0]  aw_addr_i;
    logic         w_req_i;
    logic [511:0] w_data_i;
    logic [63:0]  w_strb_i;
    logic         flush_i;
    logic         awvalid_q_o, wvalid_q_o;
    logic [63:0]  addr_q_o;
    logic         aw_busy_o;
    logic [3:0]   m_awid;
    logic [63:0]  m_awaddr;
    logic [7:0]   m_awlen;
    logic [2:0]   m_awsize;
    logic [1:0]   m_awburst;
    logic         m_awvalid, m_awready;
    logic [511:0] m_wdata;
    logic [63:0]  m_wstrb;
    logic         m_wlast, m_wvalid, m_wready;
    logic [3:0]   m_bid;
    logic [1:0]   m_bresp;
    logic         m_bvalid, m_bready;
    logic [3:0]   outst_cnt_o;
    logic         idle_o, flush_done_o;
    logic [1:0]   err_o;

    int n_chk = 0;
    int n_err = 0;
    int n_done;

    always #5 clk_i = ~clk_i;

    hawk_axi_wr_chnl dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .aw_req_i    (aw_req_i),
        .aw_addr_i   (aw_addr_i),
        .w_req_i     (w_req_i),
        .w_data_i    (w_data_i),
        .w_strb_i    (w_strb_i),
        .flush_i     (flush_i),
        .awvalid_q_o (awvalid_q_o),
        .wvalid_q_o  (wvalid_q_o),
        .addr_q_o    (addr_q_o),
        .aw_busy_o   (aw_busy_o),
        .m_awid      (m_awid),
        .m_awaddr    (m_awaddr),
        .m_awlen     (m_awlen),
        .m_awsize    (m_awsize),
        .m_awburst   (m_awburst),
        .m_awvalid   (m_awvalid),
        .m_awready   (m_awready),
        .m_wdata     (m_wdata),
        .m_wstrb     (m_wstrb),
        .m_wlast     (m_wlast),
        .m_wvalid    (m_wvalid),
        .m_wready    (m_wready),
        .m_bid       (m_bid),
        .m_bresp     (m_bresp),
        .m_bvalid    (m_bvalid),
        .m_bready    (m_bready),
        .outst_cnt_o (outst_cnt_o),
        .idle_o      (idle_o),
        .flush_done_o(flush_done_o),
        .err_o       (err_o)
    );

    task automatic chk(input string tag, input logic [511:0] got,
                       input logic [511:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        aw_req_i  = 1'b0;
        aw_addr_i = '0;
        w_req_i   = 1'b0;
        w_data_i  = '0;
        w_strb_i  = '0;
        flush_i   = 1'b0;
        m_awready = 1'b0;
        m_wready  = 1'b0;
        m_bid     = '0;
        m_bresp   = 2'b00;
        m_bvalid  = 1'b0;
        rst_ni    = 1'b0;
        step();
        step();
        rst_ni = 1'b1;
        step();
    endtask

    // One AW load cycle followed by the handshake cycle (awready must be 1).
    task automatic aw_write(input logic [63:0] a);
        aw_req_i  = 1'b1;
        aw_addr_i = a;
        step();
        aw_req_i = 1'b0;
        step();
    endtask

    task automatic b_resp(input logic [1:0] r);
        m_bresp  = r;
        m_bvalid = 1'b1;
        step();
        m_bvalid = 1'b0;
        m_bresp  = 2'b00;
    endtask

    initial begin
        do_reset();
        chk("rst_awvalid", awvalid_q_o, 0);
        chk("rst_wvalid", wvalid_q_o, 0);
        chk("rst_addr", addr_q_o, 0);
        chk("rst_cnt", outst_cnt_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_idle", idle_o, 1);
        chk("rst_done", flush_done_o, 0);
        chk("rst_bready", m_bready, 0);
        chk("awlen", m_awlen, 0);
        chk("awsize", m_awsize, 6);
        chk("awburst", m_awburst, 1);
        chk("wlast", m_wlast, 1);
        chk("awid", m_awid, 0);

        // single write
        m_awready = 1'b1;
        m_wready  = 1'b1;
        aw_req_i  = 1'b1;
        aw_addr_i = 64'h1000;
        w_req_i   = 1'b1;
        w_data_i  = {32{16'h1234}};
        w_strb_i  = '1;
        step();
        aw_req_i = 1'b0;
        w_req_i  = 1'b0;
        chk("s_awvalid", m_awvalid, 1);
        chk("s_wvalid", m_wvalid, 1);
        chk("s_awaddr", m_awaddr, 64'h1000);
        chk("s_wdata", m_wdata, {32{16'h1234}});
        chk("s_wstrb", m_wstrb, {64{1'b1}});
        chk("s_cnt0", outst_cnt_o, 0);
        step();
        chk("s_awclr", m_awvalid, 0);
        chk("s_wclr", m_wvalid, 0);
        chk("s_cnt1", outst_cnt_o, 1);
        chk("s_bready", m_bready, 1);
        chk("s_busy", idle_o, 0);
        b_resp(2'b00);
        chk("s_cntb", outst_cnt_o, 0);
        chk("s_idle", idle_o, 1);
        chk("s_err", err_o, 0);

        // backpressure
        do_reset();
        aw_req_i  = 1'b1;
        aw_addr_i = 64'h1000;
        step();
        aw_req_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            aw_req_i  = (i == 1);
            aw_addr_i = 64'h2000;
            chk("bp_valid", m_awvalid, 1);
            chk("bp_addr", m_awaddr, 64'h1000);
            chk("bp_busy", aw_busy_o, 1);
            step();
        end
        aw_req_i = 1'b0;
        chk("bp_addr_end", addr_q_o, 64'h1000);
        chk("bp_err", err_o, 2'b10);
        m_awready = 1'b1;
        step();
        chk("bp_rel", m_awvalid, 0);
        chk("bp_cnt", outst_cnt_o, 1);

        // credit limit
        do_reset();
        m_awready = 1'b1;
        for (int i = 0; i < 8; i++) aw_write(64'h100 * i);
        chk("cr_cnt8", outst_cnt_o, 8);
        chk("cr_busy", aw_busy_o, 1);
        chk("cr_err0", err_o, 0);
        aw_req_i  = 1'b1;
        aw_addr_i = 64'h9000;
        step();
        aw_req_i = 1'b0;
        chk("cr_drop", awvalid_q_o, 0);
        chk("cr_err", err_o, 2'b10);
        b_resp(2'b00);
        chk("cr_cnt7", outst_cnt_o, 7);
        chk("cr_free", aw_busy_o, 0);
        aw_req_i  = 1'b1;
        aw_addr_i = 64'hA000;
        step();
        aw_req_i = 1'b0;
        chk("cr_acc", awvalid_q_o, 1);
        chk("cr_addr", addr_q_o, 64'hA000);
        step();
        chk("cr_cnt8b", outst_cnt_o, 8);

        // simultaneous AW and B handshake
        do_reset();
        m_awready = 1'b1;
        for (int i = 0; i < 3; i++) aw_write(64'h40 * i);
        chk("sim_cnt3", outst_cnt_o, 3);
        aw_req_i  = 1'b1;
        aw_addr_i = 64'h3000;
        step();
        aw_req_i = 1'b0;
        m_bvalid = 1'b1;
        step();
        m_bvalid = 1'b0;
        chk("sim_cnt", outst_cnt_o, 3);
        chk("sim_awclr", awvalid_q_o, 0);

        // flush while streaming
        do_reset();
        m_awready = 1'b1;
        m_wready  = 1'b1;
        w_strb_i  = '1;
        n_done    = 0;
        for (int i = 0; i < 64; i++) begin
            aw_req_i  = 1'b1;
            aw_addr_i = 64'h4000 + 64'(64 * i);
            w_req_i   = 1'b1;
            w_data_i  = 512'(i + 1);
            flush_i   = (i == 10 || i == 20);
            m_bvalid  = 1'b0;
            step();
            if (flush_done_o) n_done++;
            if (i == 5) begin
                chk("fl_addr5", m_awaddr, 64'h4140);
                chk("fl_data5", m_wdata, 512'd6);
            end
            aw_req_i = 1'b0;
            w_req_i  = 1'b0;
            flush_i  = 1'b0;
            m_bvalid = (i > 0);
            step();
            if (flush_done_o) n_done++;
        end
        m_bvalid = 1'b0;
        chk("fl_cnt1", outst_cnt_o, 1);
        chk("fl_early", n_done, 0);
        b_resp(2'b00);
        chk("fl_cnt0", outst_cnt_o, 0);
        chk("fl_done_b", flush_done_o, 0);
        step();
        chk("fl_done", flush_done_o, 1);
        step();
        chk("fl_done_off", flush_done_o, 0);
        chk("fl_err", err_o, 0);

        // flush while idle: pulse two cycles after flush_i
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        chk("fi_d1", flush_done_o, 0);
        step();
        chk("fi_d2", flush_done_o, 1);
        step();
        chk("fi_d3", flush_done_o, 0);

        // bresp error stickiness
        do_reset();
        m_awready = 1'b1;
        aw_write(64'h5000);
        b_resp(2'b10);
        chk("er_set", err_o, 2'b01);
        aw_write(64'h5040);
        b_resp(2'b00);
        chk("er_sticky", err_o, 2'b01);
        chk("er_cnt", outst_cnt_o, 0);
        do_reset();
        chk("er_clr", err_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
